// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: bus widths,
// arbiter state encoding and the default slave-ack watchdog limit.
package wb_arb_pkg;

    // Wishbone classic bus widths
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    // Watchdog limit in clocks, only meaningful when WB_ARB_TIMEOUT_EN is defined
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // Arbiter states: IDLE has no owner, BUSY forwards the granted master
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Index width needed to address num_masters masters (legal range 2..4)
    function automatic int unsigned idx_width(input int unsigned num_masters);
        return (num_masters > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: scans the request vector starting one
// position after the previous winner and returns the first requester as a
// one-hot vector plus its index.
module rr_select #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   valid
);

    logic [IDX_W-1:0] cand;

    // Walk offsets 1..N from last so the previous winner is checked last
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            cand = IDX_W'((32'(last) + off) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone round-robin arbiter: NUM_MASTERS masters share one slave port.
// A master owns the slave from grant until it drops m_cyc_i; every handover
// passes through one IDLE clock. Request signals are mirrored
// combinationally from the owner, responses are routed back only to it.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a slave-ack watchdog
// that errors the owner after TIMEOUT_CYCLES unanswered strobe cycles.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         wbs_clk_i,
    input  logic                         wbs_rst_i,
    // Master side
    input  logic [NUM_MASTERS-1:0]       m_cyc_i,
    input  logic [NUM_MASTERS-1:0]       m_stb_i,
    input  logic [NUM_MASTERS-1:0]       m_we_i,
    input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
    input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]       m_ack_o,
    output logic [NUM_MASTERS-1:0]       m_err_o,
    // Slave side
    output logic                         s_cyc_o,
    output logic                         s_stb_o,
    output logic                         s_we_o,
    output logic [SEL_W-1:0]             s_sel_o,
    output logic [ADR_W-1:0]             s_adr_o,
    output logic [DAT_W-1:0]             s_dat_o,
    input  logic [DAT_W-1:0]             s_dat_i,
    input  logic                         s_ack_i,
    input  logic                         s_err_i,
    // Current owner, one-hot, zero when idle
    output logic [NUM_MASTERS-1:0]       gnt_o
);

    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       gnt_idx_q;
    logic [IDX_W-1:0]       last_q;
    logic                   rst_sync_q;
    logic                   busy;
    logic                   to_fire;

    logic [NUM_MASTERS-1:0] sel_gnt;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_valid;

    // Hold the FSM in reset for one extra edge after wbs_rst_i releases
    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            rst_sync_q <= 1'b1;
        end else begin
            rst_sync_q <= 1'b0;
        end
    end

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_select (
        .req     (m_cyc_i),
        .last    (last_q),
        .gnt     (sel_gnt),
        .gnt_idx (sel_idx),
        .valid   (sel_valid)
    );

    // Arbiter FSM: grant from IDLE, release when the owner drops cyc
    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state_q   <= IDLE;
            gnt_o     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(NUM_MASTERS - 1);
        end else if (rst_sync_q) begin
            state_q   <= IDLE;
            gnt_o     <= '0;
            gnt_idx_q <= '0;
            last_q    <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q   <= BUSY;
                        gnt_o     <= sel_gnt;
                        gnt_idx_q <= sel_idx;
                        last_q    <= sel_idx;
                    end
                end
                BUSY: begin
                    // Pending strobes and other requests do not delay the release
                    if (!m_cyc_i[gnt_idx_q]) begin
                        state_q <= IDLE;
                        gnt_o   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_o   <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Watchdog fires on the clock after TIMEOUT_CYCLES unanswered strobes
    always_comb begin
        to_fire = busy && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    end

    // Count stalled strobe cycles; any response, a fire or a release clears it
    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            to_cnt_q <= '0;
        end else if (rst_sync_q || !busy || !m_cyc_i[gnt_idx_q]) begin
            to_cnt_q <= '0;
        end else if (to_fire || s_ack_i || s_err_i) begin
            to_cnt_q <= '0;
        end else if (s_stb_o) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    // No watchdog: errors come only from the slave
    always_comb begin
        to_fire = 1'b0;
    end
`endif

    // Mirror the owner onto the slave port and route responses back to it
    always_comb begin
        busy    = (state_q == BUSY);
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy) begin
            s_cyc_o            = m_cyc_i[gnt_idx_q];
            s_stb_o            = m_stb_i[gnt_idx_q] & ~to_fire;
            s_we_o             = m_we_i[gnt_idx_q];
            s_sel_o            = m_sel_i[gnt_idx_q*SEL_W +: SEL_W];
            s_adr_o            = m_adr_i[gnt_idx_q*ADR_W +: ADR_W];
            s_dat_o            = m_dat_i[gnt_idx_q*DAT_W +: DAT_W];
            m_ack_o[gnt_idx_q] = s_ack_i;
            m_err_o[gnt_idx_q] = s_err_i | to_fire;
        end
    end

    // Read data is broadcast unconditionally; ack selects the consumer
    assign m_dat_o = s_dat_i;

endmodule
